// File: rtl/stress_ramp_ctrl.sv
// stress_ramp_ctrl: sequences load-reset hold, toggle-rate ramp up/down and
// steady dwell for logic/BRAM/DSP stress blocks.
// Optional heartbeat watchdog: define STRESS_RAMP_WDOG_EN.
module stress_ramp_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned STEP         = 5,
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned WDOG_CYCLES  = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [6:0] target_rate,
    input  logic       heartbeat,
    output logic       rst_out,
    output logic [6:0] toggle_rate,
    output logic       busy,
    output logic       at_target,
    output logic       fault
);

    localparam int unsigned HW    = $clog2(RST_CYCLES + 1);
    localparam int unsigned DW    = $clog2(DWELL_CYCLES + 1);
    localparam logic [7:0]  STEP8 = 8'(STEP);
    localparam logic [6:0]  STEP7 = 7'(STEP);
    localparam logic [6:0]  MAX_RATE = 7'd100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RAMP_UP,
        S_STEADY,
        S_RAMP_DOWN
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      rate_q, rate_d;
    logic [6:0]      floor_q, floor_d;
    logic [6:0]      target_q, target_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            stop_seen_q, stop_seen_d;
    logic            rst_out_q, rst_out_d;
    logic            busy_q, busy_d;
    logic            at_target_q, at_target_d;
    logic            fault_q;
    logic            wdog_trip_c;

    logic [6:0]      eff_tgt_c;
    logic            stop_any_c;
    logic            dwell_done_c;
    logic [7:0]      up_sum_c;
    logic [6:0]      up_next_c;
    logic [6:0]      floor_eff_c;
    logic [7:0]      floor_plus_c;
    logic [6:0]      down_next_c;

    // Effective target, stop request and saturating step arithmetic.
    always_comb begin
        eff_tgt_c    = (target_rate > MAX_RATE) ? MAX_RATE : target_rate;
        stop_any_c   = stop | stop_seen_q;
        dwell_done_c = (dwell_q == DW'(DWELL_CYCLES - 1));
        up_sum_c     = {1'b0, rate_q} + STEP8;
        up_next_c    = (up_sum_c >= {1'b0, target_q}) ? target_q : up_sum_c[6:0];
        floor_eff_c  = stop_any_c ? 7'd0 : floor_q;
        floor_plus_c = {1'b0, floor_eff_c} + STEP8;
        down_next_c  = ({1'b0, rate_q} <= floor_plus_c) ? floor_eff_c : (rate_q - STEP7);
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        floor_d     = floor_q;
        target_d    = target_q;
        hold_d      = '0;
        dwell_d     = '0;
        stop_seen_d = stop_seen_q | (stop && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (start && !stop && !fault_q) begin
                    target_d = eff_tgt_c;
                    state_d  = S_HOLD_RST;
                end
            end
            S_HOLD_RST: begin
                if (stop_any_c) begin
                    state_d = S_IDLE;
                end else if (hold_q == HW'(RST_CYCLES - 1)) begin
                    state_d = (target_q == 7'd0) ? S_STEADY : S_RAMP_UP;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RAMP_UP: begin
                if (stop_any_c) begin
                    floor_d = 7'd0;
                    state_d = S_RAMP_DOWN;
                end else if (dwell_done_c) begin
                    rate_d = up_next_c;
                    if (up_next_c == target_q) begin
                        state_d = S_STEADY;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            S_STEADY: begin
                target_d = eff_tgt_c;
                if (stop_any_c || wdog_trip_c) begin
                    floor_d = 7'd0;
                    state_d = S_RAMP_DOWN;
                end else if (eff_tgt_c > rate_q) begin
                    state_d = S_RAMP_UP;
                end else if (eff_tgt_c < rate_q) begin
                    floor_d = eff_tgt_c;
                    state_d = S_RAMP_DOWN;
                end
            end
            S_RAMP_DOWN: begin
                floor_d = floor_eff_c;
                if (dwell_done_c) begin
                    rate_d = down_next_c;
                    if (down_next_c == floor_eff_c) begin
                        state_d = (floor_eff_c != 7'd0) ? S_STEADY : S_IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Leaving to IDLE always parks the rate at zero and forgets the stop.
        if (state_d == S_IDLE) begin
            rate_d      = 7'd0;
            stop_seen_d = 1'b0;
        end

        rst_out_d   = (state_d == S_IDLE) || (state_d == S_HOLD_RST);
        busy_d      = (state_d != S_IDLE);
        at_target_d = (state_d == S_STEADY);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rate_q      <= 7'd0;
            floor_q     <= 7'd0;
            target_q    <= 7'd0;
            hold_q      <= '0;
            dwell_q     <= '0;
            stop_seen_q <= 1'b0;
            rst_out_q   <= 1'b1;
            busy_q      <= 1'b0;
            at_target_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            floor_q     <= floor_d;
            target_q    <= target_d;
            hold_q      <= hold_d;
            dwell_q     <= dwell_d;
            stop_seen_q <= stop_seen_d;
            rst_out_q   <= rst_out_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

`ifdef STRESS_RAMP_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);

    logic            hb_q;
    logic [WD_W-1:0] wdog_q;
    logic            hb_edge_c;

    // Heartbeat edge detect and STEADY-only timeout compare.
    always_comb begin
        hb_edge_c   = heartbeat ^ hb_q;
        wdog_trip_c = (state_q == S_STEADY) && !hb_edge_c &&
                      (wdog_q == WD_W'(WDOG_CYCLES - 1));
    end

    // Watchdog counter and sticky fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_q    <= 1'b0;
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            hb_q <= heartbeat;
            if ((state_q != S_STEADY) || hb_edge_c) begin
                wdog_q <= '0;
            end else if (!wdog_trip_c) begin
                wdog_q <= wdog_q + WD_W'(1);
            end
            fault_q <= fault_q | wdog_trip_c;
        end
    end
`else
    logic unused_hb;

    // No watchdog: heartbeat is ignored and fault is tied low.
    assign unused_hb   = heartbeat ^ (WDOG_CYCLES == 0);
    assign wdog_trip_c = 1'b0;
    assign fault_q     = 1'b0;
`endif

    assign rst_out     = rst_out_q;
    assign toggle_rate = rate_q;
    assign busy        = busy_q;
    assign at_target   = at_target_q;
    assign fault       = fault_q;

endmodule
